// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO.
//
// Contents:
//   FifoWidthDefault / FifoDepthDefault - default word width and entry count.
//   fifo_err_t                          - overflow/underflow flag pair.
//   ptr_width()                         - pointer width for a given depth.
package fifo_pkg;

  localparam int unsigned FifoWidthDefault = 8;
  localparam int unsigned FifoDepthDefault = 8;

  // Registered error flags, kept together because they share update rules.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Address width needed to index 'depth' entries. Never returns less than one bit,
  // so a degenerate depth still yields a legal vector declaration.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Simple dual-port register array for fifo_sync.
//
// Ports:
//   clk    - clock, all updates on the rising edge
//   rst    - synchronous active-high reset; clears only the read-data register
//   we     - write enable; wdata is stored at waddr
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; mem[raddr] is loaded into rdata
//   raddr  - read address
//   rdata  - registered read data, holds when re is low
//
// A read and a write to the same address at the same edge return the old word. The FIFO
// relies on this when it is full and a simultaneous push/pop targets the head slot.
module fifo_sync_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FifoWidthDefault,
  parameter int unsigned DEPTH = FifoDepthDefault,
  parameter int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Storage is deliberately not reset.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock synchronous FIFO with registered read data.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset; discards contents, clears d_out and flags
//   wr_en     - push request; accepted when not full, or when full with rd_en also high
//   rd_en     - pop request; accepted when not empty
//   d_in      - write data
//   d_out     - registered head word, valid after the accepting edge; holds otherwise
//   full      - FIFO holds FIFO_DEPTH words
//   empty     - FIFO holds no words
//   overflow  - a write was rejected because the FIFO was full (no concurrent read)
//   underflow - a read was rejected because the FIFO was empty
//
// Build option: define FIFO_SYNC_STICKY_ERR_EN to make overflow/underflow sticky until rst.
// Without it both are one-cycle pulses.
//
// FIFO_DEPTH must be a power of two, 2 or more, so the pointers wrap by natural rollover.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FifoWidthDefault,
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] d_in,
  output logic [FIFO_WIDTH-1:0] d_out,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW = ptr_width(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [AW-1:0] PtrOne     = AW'(1);
  localparam logic [CW-1:0] CntOne     = CW'(1);
  localparam logic [CW-1:0] DepthCount = CW'(FIFO_DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_err_t     err_q, err_d, err_evt;

  logic wr_accept;
  logic rd_accept;

  // Status is decoded straight from the registered count.
  assign full  = (count_q == DepthCount);
  assign empty = (count_q == '0);

  // A full FIFO still takes a write when a read frees the head slot at the same edge.
  assign wr_accept = wr_en && (!full || rd_en);
  assign rd_accept = rd_en && !empty;

  // Error events: the rejected request leaves pointers, count and d_out untouched.
  always_comb begin
    err_evt           = '0;
    err_evt.overflow  = wr_en && full && !rd_en;
    err_evt.underflow = rd_en && empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
`ifdef FIFO_SYNC_STICKY_ERR_EN
    err_d = err_q | err_evt;
`else
    err_d = err_evt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;

  fifo_sync_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (d_in),
    .re    (rd_accept),
    .raddr (rd_ptr_q),
    .rdata (d_out)
  );

`ifndef SYNTHESIS
  // Occupancy can never exceed the storage size.
  a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= DepthCount);
  // full and empty are mutually exclusive for any legal depth.
  a_full_xor_empty: assert property (@(posedge clk) disable iff (rst) !(full && empty));
  // Pointer distance always matches the occupancy, modulo the depth.
  a_ptr_count: assert property (@(posedge clk) disable iff (rst)
    (wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]);
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync. A queue acts as the reference FIFO:
// words are pushed when a write should be accepted and popped into the expected d_out
// when a read should be accepted; outputs are compared 1 ns after each rising edge.
module tb_fifo_sync;

  localparam int unsigned W = 8;
  localparam int unsigned D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] d_in = '0;
  logic [W-1:0] d_out;
  logic         full;
  logic         empty;
  logic         overflow;
  logic         underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] exp_dout = '0;
  logic         exp_ovf = 1'b0;
  logic         exp_udf = 1'b0;

  fifo_sync #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .d_in      (d_in),
    .d_out     (d_out),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference state.
  task automatic chk_all(input string tag);
    chk({tag, ".d_out"}, 32'(d_out), 32'(exp_dout));
    chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(sb.size() == D));
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));
  endtask

  // One clock with the given requests; the model is updated from pre-edge occupancy.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [W-1:0] d);
    bit ovf_evt, udf_evt, rd_ok, wr_ok;
    ovf_evt = w && (sb.size() == D) && !r;
    udf_evt = r && (sb.size() == 0);
    rd_ok   = r && (sb.size() > 0);
    wr_ok   = w && ((sb.size() < D) || r);
    if (rd_ok) exp_dout = sb.pop_front();
    if (wr_ok) sb.push_back(d);
`ifdef FIFO_SYNC_STICKY_ERR_EN
    exp_ovf = exp_ovf | ovf_evt;
    exp_udf = exp_udf | udf_evt;
`else
    exp_ovf = ovf_evt;
    exp_udf = udf_evt;
`endif
    wr_en = w;
    rd_en = r;
    d_in  = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_all(tag);
  endtask

  // Reset for one edge, with a write request held to show reset takes priority.
  task automatic do_reset(input string tag);
    rst   = 1'b1;
    wr_en = 1'b1;
    d_in  = 8'hA5;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    sb.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset("reset");

    // Basic order.
    for (int i = 1; i <= 3; i++) cycle("basic_wr", 1'b1, 1'b0, W'(i));
    for (int i = 0; i < 3; i++) cycle("basic_rd", 1'b0, 1'b1, '0);

    // Interleaved single write / single read.
    for (int i = 0; i <= 10; i++) begin
      cycle("ilv_wr", 1'b1, 1'b0, W'(i));
      cycle("ilv_rd", 1'b0, 1'b1, '0);
    end

    // Fill past full, then drain past empty.
    do_reset("reset_full");
    for (int i = 0; i < 10; i++) cycle("fill_wr", 1'b1, 1'b0, W'(i));
    for (int i = 0; i < 10; i++) cycle("drain_rd", 1'b0, 1'b1, '0);

    // Simultaneous push/pop on empty, then on one word.
    do_reset("reset_sim");
    cycle("sim_empty", 1'b1, 1'b1, W'(5));
    cycle("sim_one", 1'b1, 1'b1, W'(7));
    cycle("sim_drain", 1'b0, 1'b1, '0);

    // Simultaneous push/pop while full.
    do_reset("reset_simfull");
    for (int i = 0; i < 8; i++) cycle("sf_wr", 1'b1, 1'b0, W'(8'h10 + i));
    cycle("sf_both", 1'b1, 1'b1, W'(8'h55));
    for (int i = 0; i < 8; i++) cycle("sf_rd", 1'b0, 1'b1, '0);

    // Reset mid-operation.
    do_reset("reset_mid0");
    cycle("mid_wr", 1'b1, 1'b0, W'(2));
    cycle("mid_wr", 1'b1, 1'b0, W'(5));
    do_reset("reset_mid");
    cycle("mid_rd", 1'b0, 1'b1, '0);

    // Wrap-around.
    do_reset("reset_wrap");
    for (int i = 0; i < 8; i++) cycle("wrap_wr1", 1'b1, 1'b0, W'(i));
    for (int i = 0; i < 4; i++) cycle("wrap_rd1", 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) cycle("wrap_wr2", 1'b1, 1'b0, W'(i));
    for (int i = 0; i < 8; i++) cycle("wrap_rd2", 1'b0, 1'b1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Single-clock synchronous FIFO with parameterised width and depth.
- Provides registered read data, full/empty status, and one-cycle overflow/underflow error pulses.
- Used as a general-purpose rate/burst buffer between two blocks in the same clock domain.

Parameters:
- FIFO_WIDTH, 8, data word width in bits.
- FIFO_DEPTH, 8, number of storage entries; must be a power of two, 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request; d_in is pushed on the clk rising edge when accepted.
- rd_en  input  1  read request; head word is popped when accepted.
- d_in  input  FIFO_WIDTH  write data.
- d_out  output  FIFO_WIDTH  registered read data.
- full  output  1  high when the FIFO holds FIFO_DEPTH words.
- empty  output  1  high when the FIFO holds 0 words.
- overflow  output  1  one-cycle pulse: write rejected because the FIFO was full.
- underflow  output  1  one-cycle pulse: read rejected because the FIFO was empty.

Behaviour:
- Storage: FIFO_DEPTH x FIFO_WIDTH register array.
- Pointers: wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH with natural binary rollover.
- Occupancy: count, $clog2(FIFO_DEPTH)+1 bits.
- Status decode: full = (count == FIFO_DEPTH); empty = (count == 0). Both are combinational from the registered count, so there is no extra lag.
- Reset (rst high at a clk edge):
  - wr_ptr, rd_ptr, count = 0; d_out = 0; overflow = 0; underflow = 0.
  - Resulting outputs: empty = 1, full = 0.
  - Memory contents are not cleared.
  - Reset overrides any wr_en/rd_en in the same cycle.
  - Reset mid-operation discards all stored data.
- Write acceptance: wr_en && (!full || rd_en). Accepted write stores d_in at mem[wr_ptr] and advances wr_ptr.
- Read acceptance: rd_en && !empty.
  - Accepted read loads d_out <= mem[rd_ptr] at the same edge and advances rd_ptr. Data is valid right after the sampling edge (one-cycle latency).
  - d_out holds its last value when no read is accepted.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both are accepted; count is unchanged.
  - Full: both are accepted (the read frees a slot); overflow = 0.
  - Empty: only the write is accepted; underflow pulses; d_out is unchanged. The written word is readable on the next read.
- overflow: registered, high for exactly the cycle after an edge where wr_en && full && !rd_en. FIFO state is unchanged by the rejected write.
- underflow: registered, high for the cycle after an edge where rd_en && empty. Pointers and d_out are unchanged.
- Wrap-around: pointers roll from FIFO_DEPTH-1 to 0 seamlessly. Data order is strictly preserved across any number of wraps.

Optional Feature:
- Macro: FIFO_SYNC_STICKY_ERR_EN.
- Defined: overflow and underflow are sticky. Once set, each stays high until rst; normal FIFO operation continues regardless.
- Undefined: both are one-cycle pulses, as specified in Behaviour.

Decomposition:
- Shared package fifo_pkg: default width/depth localparams and a pointer-width helper function (clog2 wrapper).
- Optional sub-module fifo_sync_mem: simple dual-port register array with a synchronous write port and a registered read port.
- Pointer, count and flag logic stay in fifo_sync.

Test Plan:
- Basic order: reset; write 1, 2, 3 in separate cycles; then three reads -> d_out = 1, 2, 3 after each read edge; empty = 1 after the third read.
- Interleaved: for i = 0..10, write i then read -> each read returns i; empty is high between pairs; no error flags.
- Full/overflow: write 0..9 with no reads.
  - Full rises after the 8th write; overflow pulses on the writes of 8 and 9.
  - Ten reads return 0..7, then underflow pulses twice with d_out held at 7.
- Simultaneous: with the FIFO empty, assert wr_en + rd_en with d_in = 5 -> underflow pulses, count = 1. Then wr_en + rd_en with d_in = 7 -> d_out = 5, count stays 1.
- Mid-operation reset: write 2, 5; pulse rst for one cycle -> empty = 1, d_out = 0. A following read returns no data and underflow pulses.
- Wrap-around: write 0..7 (full); read 4 -> 0..3; write 0..3 (full again); read 8 -> 4, 5, 6, 7, 0, 1, 2, 3; then empty, with no flags during the sequence.
